// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared RDW/priority constants and latency-split helpers for the RAM wrappers
package ram_pkg;

  localparam string RDW_OLD = "old";
  localparam string RDW_NEW = "new";
  localparam string PRIO_A  = "a";
  localparam string PRIO_B  = "b";

  // The array stage always costs one cycle; the rest is split, input side taking the odd one.
  function automatic int output_latency(input int lat);
    return (lat - 1) >> 1;
  endfunction

  function automatic int input_latency(input int lat);
    return (lat - 1) - ((lat - 1) >> 1);
  endfunction

endpackage

// File: rtl/ram_delay_line.sv
// rtl/ram_delay_line.sv - clock-enabled, synchronously reset shift register; depth 0 is a wire
module ram_delay_line #(
  parameter int width = 1,
  parameter int depth = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clken_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  if (depth == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk_i ^ reset_i ^ clken_i;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [width-1:0] stage_q [depth];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int i = 0; i < depth; i++) stage_q[i] <= '0;
      end else if (clken_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < depth; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[depth-1];
  end

endmodule

// File: rtl/ram_dual_port_rdw.sv
// rtl/ram_dual_port_rdw.sv - true dual-port RAM with split latency pipelines, RDW mode and write priority
// Optional sticky collision flag/address outputs under RAM_DUAL_PORT_COLLISION_FLAG_EN.
module ram_dual_port_rdw
  import ram_pkg::*;
#(
  parameter int    width_a             = 32,
  parameter int    widthad_a           = 10,
  parameter int    numwords_a          = 1024,
  parameter int    width_be_a          = 4,
  parameter int    byte_width          = 8,
  parameter bit    uses_byte_enables   = 1'b0,
  parameter int    latency             = 1,
  parameter string read_during_write   = RDW_OLD,
  parameter string write_priority      = PRIO_A,
  parameter string init_file           = "",
  parameter string synthesis_ram_style = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic                  read_en_a,
  input  logic                  read_en_b,
  input  logic                  write_en_a,
  input  logic                  write_en_b,
  input  logic [widthad_a-1:0]  address_a,
  input  logic [widthad_a-1:0]  address_b,
  input  logic [width_be_a-1:0] byte_en_a,
  input  logic [width_be_a-1:0] byte_en_b,
  input  logic [width_a-1:0]    write_data_a,
  input  logic [width_a-1:0]    write_data_b,
  output logic [width_a-1:0]    read_data_a,
  output logic [width_a-1:0]    read_data_b,
  output logic                  read_valid_a,
  output logic                  read_valid_b
`ifdef RAM_DUAL_PORT_COLLISION_FLAG_EN
  ,
  output logic                  collision,
  output logic [widthad_a-1:0]  collision_addr
`endif
);

  localparam int IN_LAT     = input_latency(latency);
  localparam int OUT_LAT    = output_latency(latency);
  localparam int REQ_W      = 2 + widthad_a + width_be_a + width_a;
  localparam bit RDW_IS_NEW = (read_during_write == RDW_NEW);
  localparam int WIN        = (write_priority == PRIO_B) ? 1 : 0;
  localparam int LOSE       = 1 - WIN;

  (* ram_style = synthesis_ram_style, ram_init_file = init_file *)
  logic [width_a-1:0] mem_q [numwords_a];

  // Init image and RAM style are consumed only by the synthesis attributes above.
  logic unused_cfg;
  assign unused_cfg = (init_file == "") ^ (synthesis_ram_style == "");

  logic [REQ_W-1:0]      req_in    [2];
  logic [REQ_W-1:0]      req_s     [2];
  logic                  re_s      [2];
  logic                  we_s      [2];
  logic [widthad_a-1:0]  addr_s    [2];
  logic [width_be_a-1:0] be_s      [2];
  logic [width_a-1:0]    wd_s      [2];
  logic [width_a-1:0]    mask      [2];
  logic [width_a-1:0]    old_w     [2];
  logic [width_a-1:0]    commit    [2];
  logic [width_a-1:0]    rd_d      [2];
  logic [width_a-1:0]    rd_q      [2];
  logic [width_a-1:0]    rd_out    [2];
  logic                  in_rng    [2];
  logic                  wr        [2];
  logic                  wr_commit [2];
  logic                  rv_q      [2];
  logic                  rv_out    [2];
  logic                  collide;
  logic [width_a-1:0]    coll_word;

  assign req_in[0] = {read_en_a, write_en_a, address_a, byte_en_a, write_data_a};
  assign req_in[1] = {read_en_b, write_en_b, address_b, byte_en_b, write_data_b};

  for (genvar p = 0; p < 2; p++) begin : g_port
    ram_delay_line #(.width(REQ_W), .depth(IN_LAT)) u_req (
      .clk_i(clk), .reset_i(reset), .clken_i(clken), .d_i(req_in[p]), .q_o(req_s[p])
    );
    assign {re_s[p], we_s[p], addr_s[p], be_s[p], wd_s[p]} = req_s[p];

    ram_delay_line #(.width(width_a), .depth(OUT_LAT)) u_data (
      .clk_i(clk), .reset_i(reset), .clken_i(clken), .d_i(rd_q[p]), .q_o(rd_out[p])
    );
    ram_delay_line #(.width(1), .depth(OUT_LAT)) u_valid (
      .clk_i(clk), .reset_i(reset), .clken_i(clken), .d_i(rv_q[p]), .q_o(rv_out[p])
    );
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_rng[p] = 32'(addr_s[p]) < 32'(numwords_a);
      old_w[p]  = in_rng[p] ? mem_q[addr_s[p]] : '0;
      wr[p]     = we_s[p] && in_rng[p];
      mask[p]   = '0;
      for (int l = 0; l < width_be_a; l++) begin
        mask[p][l*byte_width +: byte_width] = {byte_width{be_s[p][l] || !uses_byte_enables}};
      end
    end

    // Same-address dual write: winner's lanes first, loser fills the lanes the winner left alone.
    collide   = wr[0] && wr[1] && (addr_s[0] == addr_s[1]);
    coll_word = (old_w[WIN] & ~(mask[WIN] | mask[LOSE]))
              | (wd_s[WIN] & mask[WIN])
              | (wd_s[LOSE] & mask[LOSE] & ~mask[WIN]);

    for (int p = 0; p < 2; p++) begin
      commit[p]    = collide ? coll_word : ((old_w[p] & ~mask[p]) | (wd_s[p] & mask[p]));
      wr_commit[p] = wr[p] && !(collide && (p == LOSE));
      rd_d[p]      = (RDW_IS_NEW && wr[p]) ? commit[p] : old_w[p];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && clken) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_commit[p]) mem_q[addr_s[p]] <= commit[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        rd_q[p] <= '0;
        rv_q[p] <= 1'b0;
      end
    end else if (clken) begin
      for (int p = 0; p < 2; p++) begin
        rv_q[p] <= re_s[p];
        if (re_s[p]) rd_q[p] <= rd_d[p];
      end
    end
  end

  assign read_data_a  = rd_out[0];
  assign read_data_b  = rd_out[1];
  assign read_valid_a = rv_out[0];
  assign read_valid_b = rv_out[1];

`ifdef RAM_DUAL_PORT_COLLISION_FLAG_EN
  logic                 collision_q;
  logic [widthad_a-1:0] collision_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      collision_q      <= 1'b0;
      collision_addr_q <= '0;
    end else if (clken && collide && !collision_q) begin
      collision_q      <= 1'b1;
      collision_addr_q <= addr_s[0];
    end
  end

  assign collision      = collision_q;
  assign collision_addr = collision_addr_q;
`endif

endmodule

// File: tb/tb_ram_dual_port_rdw.sv
// tb/tb_ram_dual_port_rdw.sv - scoreboard bench: two shared-stimulus instances ("new"/prio b lat 4, "old"/prio a lat 3)
module tb_ram_dual_port_rdw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clken;
  logic        ren_a, wen_a, ren_b, wen_b;
  logic [9:0]  addr_a, addr_b;
  logic [3:0]  be_a, be_b;
  logic [31:0] wd_a, wd_b;
  // channel 0/1: u_new port a/b, channel 2/3: u_old port a/b
  logic [31:0] rd  [4];
  logic        vld [4];
`ifdef RAM_DUAL_PORT_COLLISION_FLAG_EN
  logic        col      [2];
  logic [9:0]  col_addr [2];
`endif

  ram_dual_port_rdw #(
    .numwords_a(1000), .uses_byte_enables(1'b1), .latency(4),
    .read_during_write("new"), .write_priority("b")
  ) u_new (
    .clk(clk), .reset(reset), .clken(clken),
    .read_en_a(ren_a), .read_en_b(ren_b), .write_en_a(wen_a), .write_en_b(wen_b),
    .address_a(addr_a), .address_b(addr_b), .byte_en_a(be_a), .byte_en_b(be_b),
    .write_data_a(wd_a), .write_data_b(wd_b),
    .read_data_a(rd[0]), .read_data_b(rd[1]), .read_valid_a(vld[0]), .read_valid_b(vld[1])
`ifdef RAM_DUAL_PORT_COLLISION_FLAG_EN
    , .collision(col[0]), .collision_addr(col_addr[0])
`endif
  );

  ram_dual_port_rdw #(
    .numwords_a(1000), .uses_byte_enables(1'b1), .latency(3),
    .read_during_write("old"), .write_priority("a")
  ) u_old (
    .clk(clk), .reset(reset), .clken(clken),
    .read_en_a(ren_a), .read_en_b(ren_b), .write_en_a(wen_a), .write_en_b(wen_b),
    .address_a(addr_a), .address_b(addr_b), .byte_en_a(be_a), .byte_en_b(be_b),
    .write_data_a(wd_a), .write_data_b(wd_b),
    .read_data_a(rd[2]), .read_data_b(rd[3]), .read_valid_a(vld[2]), .read_valid_b(vld[3])
`ifdef RAM_DUAL_PORT_COLLISION_FLAG_EN
    , .collision(col[1]), .collision_addr(col_addr[1])
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q [4][$];
  int   en_cyc = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Monitor: counts enabled edges and checks every freshly produced read_valid.
  always @(posedge clk) begin
    logic adv;
    exp_t e;
    adv = clken;
    if (adv) en_cyc++;
    #2;
    if (adv) begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ch%0d unexpected read_valid: got data %h want no valid", i, rd[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("ch%0d data", i), rd[i], e.data);
            chk($sformatf("ch%0d arrival cycle", i), 32'(en_cyc), 32'(e.due));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren_a = 0; wen_a = 0; ren_b = 0; wen_b = 0;
    addr_a = '0; addr_b = '0; be_a = 4'hF; be_b = 4'hF; wd_a = '0; wd_b = '0;
  endtask

  task automatic expect_rd(input int port, input logic [31:0] d_new, input logic [31:0] d_old);
    exp_t e;
    e.data = d_new; e.due = en_cyc + 4; exp_q[port].push_back(e);
    e.data = d_old; e.due = en_cyc + 3; exp_q[2 + port].push_back(e);
  endtask

  initial begin
    idle();
    clken = 1'b1;
    reset = 1'b1;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset data ch%0d", i), rd[i], 32'h0);
      chk($sformatf("reset valid ch%0d", i), 32'(vld[i]), 32'h0);
    end
    reset = 1'b0;

    // write A, read B
    addr_a = 5; wen_a = 1; wd_a = 32'hDEADBEEF; tick();
    idle(); addr_b = 5; ren_b = 1; expect_rd(1, 32'hDEADBEEF, 32'hDEADBEEF); tick();

    // same-port read-during-write with byte enables
    idle(); addr_a = 7; wen_a = 1; wd_a = 32'h11223344; tick();
    idle(); addr_a = 7; wen_a = 1; ren_a = 1; wd_a = 32'hAABBCCDD; be_a = 4'b0101;
    expect_rd(0, 32'h11BB33DD, 32'h11223344); tick();
    idle(); addr_a = 7; ren_a = 1; expect_rd(0, 32'h11BB33DD, 32'h11BB33DD); tick();

    // dual-write collisions: full and partial lanes
    idle(); addr_a = 9; addr_b = 9; wen_a = 1; wen_b = 1; wd_a = 32'h1; wd_b = 32'h2; tick();
    idle(); addr_a = 11; wen_a = 1; wd_a = 32'h12345678; tick();
    idle(); addr_a = 11; addr_b = 11; wen_a = 1; wen_b = 1;
    wd_a = 32'hAAAAAAAA; be_a = 4'b0011; wd_b = 32'hBBBBBBBB; be_b = 4'b0110; tick();
    idle(); addr_a = 9; ren_a = 1; addr_b = 11; ren_b = 1;
    expect_rd(0, 32'h2, 32'h1); expect_rd(1, 32'h12BBBBAA, 32'h12BBAAAA); tick();

    // cross-port read during write sees old data
    idle(); addr_a = 13; wen_a = 1; wd_a = 32'h55; tick();
    idle(); addr_a = 13; wen_a = 1; wd_a = 32'h66; addr_b = 13; ren_b = 1;
    expect_rd(1, 32'h55, 32'h55); tick();
    idle(); addr_b = 13; ren_b = 1; expect_rd(1, 32'h66, 32'h66); tick();

    // write-only: no valid, read_data holds last read result
    idle(); addr_a = 20; wen_a = 1; wd_a = 32'h20202020; tick();
    idle(); repeat (6) tick();
    chk("hold data new.a", rd[0], 32'h2);
    chk("hold data old.a", rd[2], 32'h1);
`ifdef RAM_DUAL_PORT_COLLISION_FLAG_EN
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("collision flag %0d", i), 32'(col[i]), 32'h1);
      chk($sformatf("collision addr %0d", i), 32'(col_addr[i]), 32'd9);
    end
`endif

    // out-of-range address
    addr_a = 10; wen_a = 1; wd_a = 32'h10101010; tick();
    idle(); addr_a = 1010; wen_a = 1; wd_a = 32'hFFFFFFFF; tick();
    idle(); addr_a = 1010; ren_a = 1; addr_b = 10; ren_b = 1;
    expect_rd(0, 32'h0, 32'h0); expect_rd(1, 32'h10101010, 32'h10101010); tick();

    // clken freeze mid-flight
    idle(); addr_b = 5; ren_b = 1; expect_rd(1, 32'hDEADBEEF, 32'hDEADBEEF); tick();
    idle(); tick();
    clken = 1'b0; repeat (5) tick();
    clken = 1'b1; repeat (6) tick();

    // reset one cycle after a read request kills it
    addr_a = 7; ren_a = 1; addr_b = 13; ren_b = 1; tick();
    idle(); reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid reset data ch%0d", i), rd[i], 32'h0);
      chk($sformatf("mid reset valid ch%0d", i), 32'(vld[i]), 32'h0);
    end
`ifdef RAM_DUAL_PORT_COLLISION_FLAG_EN
    chk("collision cleared", 32'(col[0]), 32'h0);
`endif
    repeat (6) tick();
    addr_a = 7; ren_a = 1; expect_rd(0, 32'h11BB33DD, 32'h11BB33DD); tick();
    idle();

    for (int n = 0; n < 20; n++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ch%0d pending reads", i), 32'(exp_q[i].size()), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
